// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - falling-block game control FSM: spawn, gravity timing, move strobes, row clearing
module game_sequencer #(
    parameter int DROP_TICKS = 4,
    parameter int SPAWN_LOC  = 5
) (
    input  logic        clk,
    input  logic        restart_n,
    input  logic        start,
    input  logic        left,
    input  logic        right,
    input  logic        rotate,
    input  logic [4:0]  new_location,
    input  logic [1:0]  new_rotation,
    input  logic [31:0] new_board_state,
    input  logic        touched,
    output logic        step_a,
    output logic        step_b,
    output logic        mv_left,
    output logic        mv_right,
    output logic        mv_rotate,
    output logic [1:0]  piece_type,
    output logic [4:0]  piece_location,
    output logic [1:0]  piece_rotation,
    output logic [31:0] board_state,
    output logic [2:0]  state,
    output logic        game_over,
    output logic [7:0]  lines_cleared
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPAWN   = 3'd1,
        WAIT    = 3'd2,
        PHASE_A = 3'd3,
        PHASE_B = 3'd4,
        COMMIT  = 3'd5,
        CLEAR   = 3'd6,
        OVER    = 3'd7
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LEFT  = 2'd1;
    localparam logic [1:0] CMD_RIGHT = 2'd2;
    localparam logic [1:0] CMD_ROT   = 2'd3;

    state_t      r_state;
    logic [3:0]  r_lfsr;
    logic [7:0]  r_cnt;
    logic [1:0]  r_pend;
    logic [2:0]  r_prev;
    logic        r_step_a;
    logic        r_step_b;
    logic        r_mv_left;
    logic        r_mv_right;
    logic        r_mv_rotate;
    logic [1:0]  r_type;
    logic [4:0]  r_loc;
    logic [1:0]  r_rot;
    logic [31:0] r_board;
    logic        r_game_over;
    logic [7:0]  r_lines;

    logic [2:0]  w_edge;
    logic        w_cap_en;
    logic [1:0]  w_pend_next;
    logic        w_full_found;
    logic [2:0]  w_full_row;
    logic [31:0] w_board_shifted;
    logic [3:0]  w_lfsr_next;

    assign w_edge      = {left, right, rotate} & ~r_prev;
    assign w_cap_en    = (r_state != IDLE) && (r_state != OVER) && (r_state != PHASE_A);
    assign w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

    always_comb begin
        w_pend_next = r_pend;
        if (w_cap_en && (r_pend == CMD_NONE)) begin
            if (w_edge[2])      w_pend_next = CMD_LEFT;
            else if (w_edge[1]) w_pend_next = CMD_RIGHT;
            else if (w_edge[0]) w_pend_next = CMD_ROT;
        end
    end

    // Ascending scan so the bottom-most full row wins
    always_comb begin
        w_full_found = 1'b0;
        w_full_row   = 3'd0;
        for (int r = 0; r < 8; r++) begin
            if (&r_board[4*r +: 4]) begin
                w_full_found = 1'b1;
                w_full_row   = 3'(r);
            end
        end
    end

    always_comb begin
        w_board_shifted = r_board;
        for (int r = 1; r < 8; r++) begin
            if (3'(r) <= w_full_row) w_board_shifted[4*r +: 4] = r_board[4*(r-1) +: 4];
        end
        w_board_shifted[3:0] = 4'h0;
    end

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            r_state     <= IDLE;
            r_lfsr      <= 4'b1001;
            r_cnt       <= 8'd0;
            r_pend      <= CMD_NONE;
            r_prev      <= 3'b000;
            r_step_a    <= 1'b0;
            r_step_b    <= 1'b0;
            r_mv_left   <= 1'b0;
            r_mv_right  <= 1'b0;
            r_mv_rotate <= 1'b0;
            r_type      <= 2'd0;
            r_loc       <= 5'd0;
            r_rot       <= 2'd0;
            r_board     <= 32'd0;
            r_game_over <= 1'b0;
            r_lines     <= 8'd0;
        end else begin
            r_prev   <= {left, right, rotate};
            r_pend   <= w_pend_next;
            r_step_a <= 1'b0;
            r_step_b <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_board <= 32'd0;
                    r_lines <= 8'd0;
                    if (start) r_state <= SPAWN;
                end
                SPAWN: begin
                    r_type <= r_lfsr[1:0];
                    r_loc  <= 5'(SPAWN_LOC);
                    r_rot  <= 2'd0;
                    r_cnt  <= 8'd0;
                    r_lfsr <= w_lfsr_next;
                    if (r_board[SPAWN_LOC]) begin
                        r_state     <= OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Command is latched onto mv_* as PHASE_A begins so it is stable across both strobes
                    if (r_cnt == 8'(DROP_TICKS - 1)) begin
                        r_cnt       <= 8'd0;
                        r_state     <= PHASE_A;
                        r_step_a    <= 1'b1;
                        r_mv_left   <= (w_pend_next == CMD_LEFT);
                        r_mv_right  <= (w_pend_next == CMD_RIGHT);
                        r_mv_rotate <= (w_pend_next == CMD_ROT);
                        r_pend      <= CMD_NONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                PHASE_A: begin
                    r_state  <= PHASE_B;
                    r_step_b <= 1'b1;
                end
                PHASE_B: begin
                    r_mv_left   <= 1'b0;
                    r_mv_right  <= 1'b0;
                    r_mv_rotate <= 1'b0;
                    r_state     <= COMMIT;
                end
                COMMIT: begin
                    r_loc   <= new_location;
                    r_rot   <= new_rotation;
                    r_board <= new_board_state;
                    r_state <= touched ? CLEAR : WAIT;
                end
                CLEAR: begin
                    if (w_full_found) begin
                        r_board <= w_board_shifted;
                        if (r_lines != 8'hFF) r_lines <= r_lines + 8'd1;
                    end else begin
                        r_state <= SPAWN;
                    end
                end
                OVER: begin
                    if (start) begin
                        r_board     <= 32'd0;
                        r_lines     <= 8'd0;
                        r_game_over <= 1'b0;
                        r_state     <= SPAWN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign state          = r_state;
    assign step_a         = r_step_a;
    assign step_b         = r_step_b;
    assign mv_left        = r_mv_left;
    assign mv_right       = r_mv_right;
    assign mv_rotate      = r_mv_rotate;
    assign piece_type     = r_type;
    assign piece_location = r_loc;
    assign piece_rotation = r_rot;
    assign board_state    = r_board;
    assign game_over      = r_game_over;
    assign lines_cleared  = r_lines;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized scoreboard bench for game_sequencer
module tb_game_sequencer;

    localparam int DT = 4;
    localparam int SL = 5;

    logic        clk = 1'b0;
    logic        restart_n = 1'b0;
    logic        start = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        rotate = 1'b0;
    logic [4:0]  new_location = 5'd0;
    logic [1:0]  new_rotation = 2'd0;
    logic [31:0] new_board_state = 32'd0;
    logic        touched = 1'b0;
    logic        step_a, step_b, mv_left, mv_right, mv_rotate, game_over;
    logic [1:0]  piece_type, piece_rotation;
    logic [4:0]  piece_location;
    logic [31:0] board_state;
    logic [2:0]  state;
    logic [7:0]  lines_cleared;

    game_sequencer #(.DROP_TICKS(DT), .SPAWN_LOC(SL)) dut (
        .clk(clk), .restart_n(restart_n), .start(start),
        .left(left), .right(right), .rotate(rotate),
        .new_location(new_location), .new_rotation(new_rotation),
        .new_board_state(new_board_state), .touched(touched),
        .step_a(step_a), .step_b(step_b),
        .mv_left(mv_left), .mv_right(mv_right), .mv_rotate(mv_rotate),
        .piece_type(piece_type), .piece_location(piece_location),
        .piece_rotation(piece_rotation), .board_state(board_state),
        .state(state), .game_over(game_over), .lines_cleared(lines_cleared)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        over;
        logic [1:0]  ptype;
        logic [31:0] board;
        logic [7:0]  lines;
    } spawn_t;

    typedef struct packed {
        logic        tch;
        logic [4:0]  loc;
        logic [1:0]  rot;
        logic [31:0] board;
    } commit_t;

    spawn_t     exp_spawn[$];
    commit_t    exp_commit[$];
    logic [2:0] exp_cmd[$];

    int checks = 0;
    int errors = 0;

    logic [3:0]  m_lfsr = 4'b1001;
    logic [31:0] m_board = 32'd0;
    int          m_lines = 0;
    bit          m_over = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic summary_and_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic give_up(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
        summary_and_end();
    endtask

    // Reference: drop every full row, stack the survivors at the bottom
    function automatic logic [31:0] cleared(input logic [31:0] b, output int n);
        logic [3:0]  kept[$];
        logic [31:0] r;
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            if (b[4*i +: 4] == 4'hF) n++;
            else kept.push_back(b[4*i +: 4]);
        end
        r = 32'd0;
        for (int k = 0; k < kept.size(); k++) r[4*(7-k) +: 4] = kept[k];
        return r;
    endfunction

    task automatic spawn_expect();
        spawn_t s;
        s.over  = m_board[SL];
        s.ptype = m_lfsr[1:0];
        s.board = m_board;
        s.lines = 8'(m_lines);
        exp_spawn.push_back(s);
        m_over = s.over;
        m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    endtask

    task automatic wait_entry(input logic [2:0] s, output bit ok);
        logic [2:0] p;
        p = state;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (state == s && p != s) begin
                ok = 1'b1;
                break;
            end
            p = state;
        end
    endtask

    task automatic restart_game();
        bit ok;
        wait_entry(3'd7, ok);
        if (!ok) give_up("over_entry_timeout");
        start = 1'b1;
        m_board = 32'd0;
        m_lines = 0;
        spawn_expect();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_round(input logic [2:0] v0, input logic [2:0] v1, input logic [2:0] v2,
                             input logic tch, input logic [31:0] nb, input bit do_commit);
        bit         ok;
        logic [2:0] v[3];
        logic [2:0] pv, e, cmd;
        int         n;
        commit_t    c;
        wait_entry(3'd2, ok);
        if (!ok) give_up("wait_entry_timeout");
        v[0] = v0; v[1] = v1; v[2] = v2;
        c.tch = tch; c.loc = 5'($urandom); c.rot = 2'($urandom); c.board = nb;
        new_location = c.loc; new_rotation = c.rot; new_board_state = nb; touched = tch;
        pv = 3'b000; cmd = 3'b000;
        for (int k = 0; k < 3; k++) begin
            e = v[k] & ~pv;
            if (cmd == 3'b000 && e != 3'b000)
                cmd = e[2] ? 3'b100 : (e[1] ? 3'b010 : 3'b001);
            pv = v[k];
        end
        exp_cmd.push_back(cmd);
        m_over = 1'b0;
        if (do_commit) begin
            exp_commit.push_back(c);
            m_board = nb;
            if (tch) begin
                m_board = cleared(m_board, n);
                m_lines = (m_lines + n > 255) ? 255 : m_lines + n;
                spawn_expect();
            end
        end
        for (int k = 0; k < 3; k++) begin
            {left, right, rotate} = v[k];
            @(negedge clk);
        end
        {left, right, rotate} = 3'b000;
        if (m_over) restart_game();
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or leaves SPAWN/COMMIT
    initial begin : monitor
        logic [2:0] prev_st;
        logic [2:0] last_mv;
        int         run;
        bit         chk_b;
        spawn_t     s;
        commit_t    c;
        prev_st = 3'd0; last_mv = 3'd0; run = 0; chk_b = 1'b0;
        forever begin
            @(negedge clk);
            chk("step_a_only_in_phase_a", step_a, state == 3'd3);
            chk("step_b_only_in_phase_b", step_b, state == 3'd4);
            if (state == 3'd2) run = (prev_st == 3'd2) ? run + 1 : 1;
            if (chk_b) begin
                chk("step_b_follows_step_a", step_b, 1'b1);
                chk("mv_held_in_phase_b", {mv_left, mv_right, mv_rotate}, last_mv);
                chk_b = 1'b0;
            end
            if (step_a) begin
                chk("wait_cycles_before_step_a", run, DT);
                if (exp_cmd.size() == 0) begin
                    give_up("cmd_queue_empty");
                end else begin
                    last_mv = exp_cmd.pop_front();
                    chk("mv_in_phase_a", {mv_left, mv_right, mv_rotate}, last_mv);
                end
                chk_b = 1'b1;
            end
            if (prev_st == 3'd1 && state != 3'd1) begin
                if (exp_spawn.size() == 0) give_up("spawn_queue_empty");
                s = exp_spawn.pop_front();
                chk("spawn_next_state", state, s.over ? 3'd7 : 3'd2);
                chk("spawn_game_over", game_over, s.over);
                chk("spawn_piece_type", piece_type, s.ptype);
                chk("spawn_location", piece_location, SL);
                chk("spawn_rotation", piece_rotation, 2'd0);
                chk("spawn_board", board_state, s.board);
                chk("spawn_lines", lines_cleared, s.lines);
            end
            if (prev_st == 3'd5 && state != 3'd5) begin
                if (exp_commit.size() == 0) give_up("commit_queue_empty");
                c = exp_commit.pop_front();
                chk("commit_next_state", state, c.tch ? 3'd6 : 3'd2);
                chk("commit_location", piece_location, c.loc);
                chk("commit_rotation", piece_rotation, c.rot);
                chk("commit_board", board_state, c.board);
            end
            prev_st = state;
        end
    end

    initial begin : watchdog
        #500000;
        give_up("global_timeout");
    end

    initial begin : stimulus
        logic [31:0] nb;
        bit          ok;
        repeat (2) @(negedge clk);
        chk("reset_state", state, 3'd0);
        chk("reset_board", board_state, 32'd0);
        chk("reset_steps", {step_a, step_b}, 2'b00);
        chk("reset_game_over", game_over, 1'b0);
        chk("reset_lines", lines_cleared, 8'd0);
        chk("reset_mv", {mv_left, mv_right, mv_rotate}, 3'b000);
        restart_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release", state, 3'd0);
        @(negedge clk);
        start = 1'b1;
        spawn_expect();
        @(negedge clk);
        start = 1'b0;

        run_round(3'b000, 3'b000, 3'b000, 1'b0, 32'h1234_5678, 1'b1);
        run_round(3'b100, 3'b110, 3'b000, 1'b0, 32'h0000_0001, 1'b1);
        run_round(3'b000, 3'b000, 3'b000, 1'b1, 32'hF000_0010, 1'b1);
        run_round(3'b001, 3'b000, 3'b000, 1'b1, 32'h0000_0020, 1'b1);
        run_round(3'b010, 3'b010, 3'b011, 1'b0, 32'h0000_0000, 1'b1);
        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < 8; r++)
                nb[4*r +: 4] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            run_round(3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                      3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                      3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), nb, 1'b1);
        end

        run_round(3'b100, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0);
        wait_entry(3'd4, ok);
        if (!ok) give_up("phase_b_timeout");
        chk("mv_left_before_reset", mv_left, 1'b1);
        #2 restart_n = 1'b0;
        #1;
        chk("async_reset_state", state, 3'd0);
        chk("async_reset_step_b", step_b, 1'b0);
        chk("async_reset_mv", {mv_left, mv_right, mv_rotate}, 3'b000);
        chk("async_reset_board", board_state, 32'd0);
        chk("async_reset_lines", lines_cleared, 8'd0);
        @(negedge clk);
        restart_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_hold_after_reset", state, 3'd0);

        m_lfsr = 4'b1001;
        m_board = 32'd0;
        m_lines = 0;
        @(negedge clk);
        start = 1'b1;
        spawn_expect();
        @(negedge clk);
        start = 1'b0;
        wait_entry(3'd2, ok);
        if (!ok) give_up("respawn_timeout");
        @(negedge clk);
        chk("spawn_queue_drained", exp_spawn.size(), 0);
        chk("commit_queue_drained", exp_commit.size(), 0);
        chk("cmd_queue_drained", exp_cmd.size(), 0);
        summary_and_end();
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter DROP_TICKS, default 4: number of WAIT cycles between gravity steps; legal range 2..255.
REQ-002 SHALL have parameter SPAWN_LOC, default 5: board index where a new piece spawns.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port restart_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: level request to begin or restart a game.
REQ-006 SHALL have ports left, right and rotate, input, 1 each: player buttons, already synchronised to clk, active high.
REQ-007 SHALL have ports new_location [4:0], new_rotation [1:0], new_board_state [31:0] and touched [1], all inputs: results from the move datapath.
REQ-008 SHALL have port step_a, output, 1: one-cycle strobe; the move datapath latches its user-input decision on it.
REQ-009 SHALL have port step_b, output, 1: one-cycle strobe; the move datapath computes its new state on it.
REQ-010 SHALL have ports mv_left, mv_right and mv_rotate, output, 1 each: the move command presented to the datapath.
REQ-011 SHALL have ports piece_type [1:0], piece_location [4:0], piece_rotation [1:0] and board_state [31:0], all outputs: the current piece and board registers.
REQ-012 SHALL have ports state [2:0], game_over [1] and lines_cleared [7:0], all outputs: FSM state, end flag and line count.

Function
REQ-013 SHALL use this board map: 8 rows by 4 columns, with row r held in bits [4r+3:4r]; row 0 is the top and row 7 the bottom.
REQ-014 SHALL implement the FSM encoding IDLE=0, SPAWN=1, WAIT=2, PHASE_A=3, PHASE_B=4, COMMIT=5, CLEAR=6, OVER=7, and drive it on the state output.
REQ-015 SHALL move from IDLE to SPAWN when start=1; while in IDLE, board_state and lines_cleared SHALL hold 0.
REQ-016 SHALL, in SPAWN, load piece_type=lfsr[1:0], piece_location=SPAWN_LOC, piece_rotation=0 and drop counter=0, then advance the LFSR once.
REQ-017 SHALL, in SPAWN, go to OVER if board_state[SPAWN_LOC]=1, and otherwise go to WAIT.
REQ-018 SHALL use a 4-bit Fibonacci LFSR with seed 4'b1001 that shifts left with feedback bit lfsr[3]^lfsr[2], and that advances only on SPAWN.
REQ-019 SHALL, in WAIT, increment the drop counter each cycle and go to PHASE_A when counter == DROP_TICKS-1, clearing the counter.
REQ-020 SHALL detect a rising edge of left, right or rotate against the previous-cycle value of that button.
REQ-021 SHALL hold at most one pending command: an edge is captured only when nothing is pending, with priority left > right > rotate when edges coincide, and further edges are dropped until the pending command is consumed.
REQ-022 SHALL capture edges in every state except IDLE, OVER and PHASE_A; an edge in PHASE_A is lost.
REQ-023 SHALL, in PHASE_A, assert step_a for exactly one cycle, copy the pending command onto mv_*, clear the pending register, and go to PHASE_B.
REQ-024 SHALL, in PHASE_B, assert step_b for exactly one cycle with mv_* unchanged, then go to COMMIT.
REQ-025 SHALL clear mv_* to 0 on exit from PHASE_B.
REQ-026 SHALL, in COMMIT, register new_location, new_rotation and new_board_state into piece_location, piece_rotation and board_state.
REQ-027 SHALL leave COMMIT for CLEAR if touched=1, and otherwise for WAIT.
REQ-028 SHALL, in CLEAR, find the bottom-most full row r (all 4 bits set) once per cycle.
REQ-029 SHALL remove full row r by moving rows 0..r-1 down one row, zeroing row 0, and incrementing lines_cleared with saturation at 255.
REQ-030 SHALL leave CLEAR for SPAWN in the first cycle that finds no full row, so a removal costs one cycle per row and several full rows take several cycles.
REQ-031 SHALL hold game_over=1 in OVER.
REQ-032 SHALL, when start=1 in OVER, clear board_state, lines_cleared and game_over and go to SPAWN.
REQ-033 SHALL keep step_a and step_b at 0 in every state other than PHASE_A and PHASE_B respectively.

Reset
REQ-034 SHALL, while restart_n=0 and at any point mid-operation, immediately force state=IDLE and lfsr=4'b1001, and force all of the following to 0: every output, the counter, the pending register and the edge history.
REQ-035 SHALL stay in IDLE on the first clk edge after restart_n rises unless start=1.

Verification
REQ-036 SHALL cover: restart_n pulsed low -> state=0, board_state=0, step_a=step_b=0, game_over=0, lines_cleared=0.
REQ-037 SHALL cover: start held, no buttons, DROP_TICKS=4 -> SPAWN loads piece_type=2'b01 and piece_location=5; step_a fires on the cycle after the 4th WAIT cycle and step_b one cycle later; the second spawn gives piece_type=2'b11.
REQ-038 SHALL cover: left edge then right edge during one WAIT -> mv_left=1 and mv_right=0 during both step_a and step_b; the right edge is not replayed.
REQ-039 SHALL cover: COMMIT with touched=1 and new_board_state=32'hF000_0010 -> CLEAR gives board_state=32'h0000_0100 and lines_cleared=1, then SPAWN.
REQ-040 SHALL cover: board_state bit 5 set on entering SPAWN -> OVER with game_over=1; then start=1 -> SPAWN with board_state=0 and lines_cleared=0.
REQ-041 SHALL cover: restart_n dropped during PHASE_B -> step_b and mv_* deassert with no clock edge and state=IDLE.
